// File: rtl/cmos_pixel_packer_if.sv
// Sensor-side DVP inputs and packed-word outputs of cmos_pixel_packer.
// master drives the sensor beats, slave is the packer.
interface cmos_pixel_packer_if #(
    parameter int IN_W  = 8,
    parameter int OUT_W = 16
);
    logic             vs_i;
    logic             de_i;
    logic [IN_W-1:0]  pdata_i;
    logic             vs_o;
    logic             de_o;
    logic [OUT_W-1:0] pdata_o;
    logic             sof_o;
    logic             eol_o;
    logic             drop_o;

    modport master (
        output vs_i, de_i, pdata_i,
        input  vs_o, de_o, pdata_o, sof_o, eol_o, drop_o
    );

    modport slave (
        input  vs_i, de_i, pdata_i,
        output vs_o, de_o, pdata_o, sof_o, eol_o, drop_o
    );
endinterface

// File: rtl/cmos_pixel_packer.sv
// Packs RATIO consecutive IN_W-bit DVP beats into one word with VSYNC arming and line-end flush.
// Optional line/word counters are built when CMOS_PACK_LINECNT_EN is defined.
module cmos_pixel_packer #(
    parameter int IN_W        = 8,
    parameter int RATIO       = 2,
    parameter int MSB_FIRST   = 1,
    parameter int PAD_PARTIAL = 1,
    parameter int CNT_W       = 12
) (
    input  logic               pclk,
    input  logic               rst,
    cmos_pixel_packer_if.slave bus
`ifdef CMOS_PACK_LINECNT_EN
    ,
    output logic [CNT_W-1:0]   line_cnt_o,
    output logic [CNT_W-1:0]   word_cnt_o
`endif
);
    localparam int              OUT_W     = IN_W * RATIO;
    localparam int              BC_W      = $clog2(RATIO);
    localparam logic [BC_W-1:0] LAST_BEAT = BC_W'(RATIO - 1);
    localparam bit              PAD_EN    = (PAD_PARTIAL != 0);

    typedef enum logic [1:0] {
        S_WAIT_VS = 2'd0,
        S_IDLE    = 2'd1,
        S_PACK    = 2'd2
    } state_t;

    state_t            state_r;
    logic [BC_W-1:0]   beat_cnt_r;
    logic [OUT_W-1:0]  shift_r;
    logic              vs_r;
    logic              de_r;
    logic              sof_pending_r;

    logic              vs_rise_s;
    logic              de_fall_s;
    logic [OUT_W-1:0]  packed_s;
    logic              take_beat_s;
    logic              word_done_s;
    logic              line_end_s;
    logic              partial_s;
    logic              emit_s;
    logic              drop_s;
    logic [OUT_W-1:0]  emit_word_s;

    function automatic logic [OUT_W-1:0] place_beat(
        input logic [OUT_W-1:0] word,
        input logic [BC_W-1:0]  lane,
        input logic [IN_W-1:0]  beat
    );
        logic [OUT_W-1:0] r;
        int               base;
        r = word;
        if (MSB_FIRST != 0) begin
            base = OUT_W - IN_W * (int'(lane) + 1);
        end else begin
            base = IN_W * int'(lane);
        end
        r[base +: IN_W] = beat;
        return r;
    endfunction

    assign vs_rise_s   = bus.vs_i & ~vs_r;
    assign de_fall_s   = de_r & ~bus.de_i;
    assign packed_s    = place_beat(shift_r, beat_cnt_r, bus.pdata_i);
    assign emit_word_s = word_done_s ? packed_s : shift_r;

    // Decode this cycle's packing events; a VSYNC rise overrides any beat or line end.
    always_comb begin
        take_beat_s = 1'b0;
        word_done_s = 1'b0;
        line_end_s  = 1'b0;
        if (vs_rise_s || (state_r == S_WAIT_VS)) begin
            take_beat_s = 1'b0;
        end else begin
            take_beat_s = bus.de_i;
            word_done_s = bus.de_i & (beat_cnt_r == LAST_BEAT);
            line_end_s  = (state_r == S_PACK) & de_fall_s;
        end
        partial_s = line_end_s & (beat_cnt_r != '0);
        emit_s    = word_done_s | (partial_s & PAD_EN);
        drop_s    = partial_s & ~PAD_EN;
    end

    // Frame FSM, lane assembly and all registered outputs.
    always_ff @(posedge pclk or posedge rst) begin
        if (rst) begin
            state_r       <= S_WAIT_VS;
            beat_cnt_r    <= '0;
            shift_r       <= '0;
            vs_r          <= 1'b0;
            de_r          <= 1'b0;
            sof_pending_r <= 1'b0;
            bus.vs_o      <= 1'b0;
            bus.de_o      <= 1'b0;
            bus.pdata_o   <= '0;
            bus.sof_o     <= 1'b0;
            bus.eol_o     <= 1'b0;
            bus.drop_o    <= 1'b0;
`ifdef CMOS_PACK_LINECNT_EN
            line_cnt_o    <= '0;
            word_cnt_o    <= '0;
`endif
        end else begin
            vs_r        <= bus.vs_i;
            de_r        <= bus.de_i;
            bus.vs_o    <= bus.vs_i;
            bus.de_o    <= emit_s;
            bus.sof_o   <= emit_s & sof_pending_r;
            bus.eol_o   <= line_end_s;
            bus.drop_o  <= drop_s;
            if (emit_s) begin
                bus.pdata_o <= emit_word_s;
            end

            if (vs_rise_s) begin
                sof_pending_r <= 1'b1;
            end else if (emit_s) begin
                sof_pending_r <= 1'b0;
            end

            case (state_r)
                S_WAIT_VS: if (vs_rise_s) state_r <= S_IDLE;
                S_IDLE: begin
                    if (vs_rise_s) begin
                        state_r <= S_IDLE;
                    end else if (bus.de_i) begin
                        state_r <= S_PACK;
                    end
                end
                S_PACK:    if (vs_rise_s || line_end_s) state_r <= S_IDLE;
                default:   state_r <= S_WAIT_VS;
            endcase

            // Partial data from an interrupted frame is discarded silently.
            if (vs_rise_s || word_done_s || line_end_s) begin
                beat_cnt_r <= '0;
                shift_r    <= '0;
            end else if (take_beat_s) begin
                beat_cnt_r <= beat_cnt_r + BC_W'(1);
                shift_r    <= packed_s;
            end

`ifdef CMOS_PACK_LINECNT_EN
            if (vs_rise_s) begin
                line_cnt_o <= '0;
            end else if (line_end_s && (line_cnt_o != '1)) begin
                line_cnt_o <= line_cnt_o + CNT_W'(1);
            end
            if (emit_s) begin
                if (word_cnt_o != '1) word_cnt_o <= word_cnt_o + CNT_W'(1);
            end else if (bus.eol_o) begin
                word_cnt_o <= '0;
            end
`endif
        end
    end
endmodule

// File: tb/tb_cmos_pixel_packer.sv
// Bench for cmos_pixel_packer: three configurations share one beat stream, checked
// against directed vectors and a queue-style line model.
module tb_cmos_pixel_packer;
    logic pclk = 1'b0;
    logic rst  = 1'b1;
    always #5 pclk = ~pclk;

    cmos_pixel_packer_if #(.IN_W(8), .OUT_W(16)) if0 ();
    cmos_pixel_packer_if #(.IN_W(8), .OUT_W(32)) if1 ();
    cmos_pixel_packer_if #(.IN_W(8), .OUT_W(16)) if2 ();

`ifdef CMOS_PACK_LINECNT_EN
    logic [11:0] lc0, wc0, lc1, wc1, lc2, wc2;
`endif

    cmos_pixel_packer #(.IN_W(8), .RATIO(2), .MSB_FIRST(1), .PAD_PARTIAL(1), .CNT_W(12)) dut0 (
        .pclk(pclk), .rst(rst), .bus(if0)
`ifdef CMOS_PACK_LINECNT_EN
        , .line_cnt_o(lc0), .word_cnt_o(wc0)
`endif
    );
    cmos_pixel_packer #(.IN_W(8), .RATIO(4), .MSB_FIRST(0), .PAD_PARTIAL(1), .CNT_W(12)) dut1 (
        .pclk(pclk), .rst(rst), .bus(if1)
`ifdef CMOS_PACK_LINECNT_EN
        , .line_cnt_o(lc1), .word_cnt_o(wc1)
`endif
    );
    cmos_pixel_packer #(.IN_W(8), .RATIO(2), .MSB_FIRST(1), .PAD_PARTIAL(0), .CNT_W(12)) dut2 (
        .pclk(pclk), .rst(rst), .bus(if2)
`ifdef CMOS_PACK_LINECNT_EN
        , .line_cnt_o(lc2), .word_cnt_o(wc2)
`endif
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: per configuration, a line buffer of beats collected so far.
    int          cfg_ratio [3] = '{2, 4, 2};
    bit          cfg_msb   [3] = '{1'b1, 1'b0, 1'b1};
    bit          cfg_pad   [3] = '{1'b1, 1'b1, 1'b0};
    bit          m_armed   [3];
    bit          m_in_line [3];
    bit          m_sof     [3];
    int          m_n       [3];
    logic [7:0]  m_buf     [3][8];
    bit          m_prev_vs;
    bit          e_vs;
    bit          e_de      [3];
    bit          e_sof     [3];
    bit          e_eol     [3];
    bit          e_drop    [3];
    logic [31:0] e_data    [3];
    int          e_line;
    int          e_word;

    typedef struct {
        bit          vs;
        bit          de;
        logic [7:0]  d;
        bit          x_de;
        bit          x_sof;
        bit          x_eol;
        bit          x_drop;
        logic [15:0] x_data;
    } vec_t;
    vec_t tbl [23];

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    function automatic logic [63:0] got_vec(input int c);
        case (c)
            0:       return {27'd0, if0.vs_o, if0.de_o, if0.sof_o, if0.eol_o, if0.drop_o, 16'd0, if0.pdata_o};
            1:       return {27'd0, if1.vs_o, if1.de_o, if1.sof_o, if1.eol_o, if1.drop_o, if1.pdata_o};
            default: return {27'd0, if2.vs_o, if2.de_o, if2.sof_o, if2.eol_o, if2.drop_o, 16'd0, if2.pdata_o};
        endcase
    endfunction

    function automatic logic [63:0] exp_vec(input int c);
        return {27'd0, e_vs, e_de[c], e_sof[c], e_eol[c], e_drop[c], e_data[c]};
    endfunction

    function automatic logic [31:0] assemble(input int c, input int n);
        logic [63:0] w;
        int          sh;
        w = 64'd0;
        for (int k = 0; k < n; k++) begin
            sh = cfg_msb[c] ? 8 * (cfg_ratio[c] - 1 - k) : 8 * k;
            w  = w | (64'(m_buf[c][k]) << sh);
        end
        return w[31:0];
    endfunction

    task automatic model_reset();
        m_prev_vs = 1'b0;
        e_vs      = 1'b0;
        e_line    = 0;
        e_word    = 0;
        for (int c = 0; c < 3; c++) begin
            m_armed[c] = 1'b0; m_in_line[c] = 1'b0; m_sof[c] = 1'b0; m_n[c] = 0;
            e_de[c] = 1'b0; e_sof[c] = 1'b0; e_eol[c] = 1'b0; e_drop[c] = 1'b0;
            e_data[c] = 32'd0;
        end
    endtask

    task automatic emit(input int c, input logic [31:0] w);
        e_de[c]   = 1'b1;
        e_data[c] = w;
        e_sof[c]  = m_sof[c];
        m_sof[c]  = 1'b0;
    endtask

    task automatic model_step(input bit vs, input bit de, input logic [7:0] d);
        bit vr;
        bit prev_eol0;
        vr        = vs && !m_prev_vs;
        prev_eol0 = e_eol[0];
        e_vs      = vs;
        for (int c = 0; c < 3; c++) begin
            e_de[c] = 1'b0; e_sof[c] = 1'b0; e_eol[c] = 1'b0; e_drop[c] = 1'b0;
            if (vr) begin
                m_armed[c] = 1'b1; m_sof[c] = 1'b1; m_n[c] = 0; m_in_line[c] = 1'b0;
            end else if (m_armed[c]) begin
                if (de) begin
                    m_buf[c][m_n[c]] = d;
                    m_n[c]++;
                    m_in_line[c] = 1'b1;
                    if (m_n[c] == cfg_ratio[c]) begin
                        emit(c, assemble(c, cfg_ratio[c]));
                        m_n[c] = 0;
                    end
                end else if (m_in_line[c]) begin
                    e_eol[c] = 1'b1;
                    if (m_n[c] != 0) begin
                        if (cfg_pad[c]) emit(c, assemble(c, m_n[c]));
                        else e_drop[c] = 1'b1;
                    end
                    m_n[c] = 0;
                    m_in_line[c] = 1'b0;
                end
            end
        end
        if (vr) e_line = 0;
        else if (e_eol[0] && e_line < 4095) e_line++;
        if (e_de[0]) begin
            if (e_word < 4095) e_word++;
        end else if (prev_eol0) begin
            e_word = 0;
        end
        m_prev_vs = vs;
    endtask

    task automatic drive(input bit vs, input bit de, input logic [7:0] d);
        if0.vs_i = vs; if0.de_i = de; if0.pdata_i = d;
        if1.vs_i = vs; if1.de_i = de; if1.pdata_i = d;
        if2.vs_i = vs; if2.de_i = de; if2.pdata_i = d;
    endtask

    task automatic cycle(input bit vs, input bit de, input logic [7:0] d);
        drive(vs, de, d);
        @(posedge pclk);
        model_step(vs, de, d);
        #1;
        chk("model_r2_msb_pad", got_vec(0), exp_vec(0));
        chk("model_r4_lsb_pad", got_vec(1), exp_vec(1));
        chk("model_r2_msb_drop", got_vec(2), exp_vec(2));
`ifdef CMOS_PACK_LINECNT_EN
        chk("model_counters", {40'd0, lc0, wc0}, {40'd0, 12'(e_line), 12'(e_word)});
`endif
    endtask

    initial begin
        bit         vs_r;
        bit         de_r;
        logic [7:0] d_r;

        tbl[0]  = '{1'b0, 1'b1, 8'h11, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000};
        tbl[1]  = '{1'b0, 1'b1, 8'h22, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000};
        tbl[2]  = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000};
        tbl[3]  = '{1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000};
        tbl[4]  = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000};
        tbl[5]  = '{1'b0, 1'b1, 8'h12, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000};
        tbl[6]  = '{1'b0, 1'b1, 8'h34, 1'b1, 1'b1, 1'b0, 1'b0, 16'h1234};
        tbl[7]  = '{1'b0, 1'b1, 8'h56, 1'b0, 1'b0, 1'b0, 1'b0, 16'h1234};
        tbl[8]  = '{1'b0, 1'b1, 8'h78, 1'b1, 1'b0, 1'b0, 1'b0, 16'h5678};
        tbl[9]  = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 16'h5678};
        tbl[10] = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 16'h5678};
        tbl[11] = '{1'b0, 1'b1, 8'h01, 1'b0, 1'b0, 1'b0, 1'b0, 16'h5678};
        tbl[12] = '{1'b0, 1'b1, 8'h02, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0102};
        tbl[13] = '{1'b0, 1'b1, 8'h03, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0102};
        tbl[14] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 16'h0300};
        tbl[15] = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0300};
        tbl[16] = '{1'b0, 1'b1, 8'h9A, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0300};
        tbl[17] = '{1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0300};
        tbl[18] = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0300};
        tbl[19] = '{1'b0, 1'b1, 8'h11, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0300};
        tbl[20] = '{1'b0, 1'b1, 8'h22, 1'b1, 1'b1, 1'b0, 1'b0, 16'h1122};
        tbl[21] = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 16'h1122};
        tbl[22] = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 16'h1122};

        drive(1'b0, 1'b0, 8'h00);
        model_reset();
        repeat (3) @(posedge pclk);
        #1;
        chk("reset_r2", got_vec(0), 64'd0);
        chk("reset_r4", got_vec(1), 64'd0);
        chk("reset_drop", got_vec(2), 64'd0);
        #2 rst = 1'b0;

        for (int i = 0; i < 23; i++) begin
            cycle(tbl[i].vs, tbl[i].de, tbl[i].d);
            chk($sformatf("vec%0d", i), got_vec(0),
                {27'd0, tbl[i].vs, tbl[i].x_de, tbl[i].x_sof, tbl[i].x_eol, tbl[i].x_drop,
                 16'd0, tbl[i].x_data});
        end

        // RATIO=4, LSB-first: four beats form one word
        cycle(1'b0, 1'b1, 8'hAA);
        cycle(1'b0, 1'b1, 8'hBB);
        cycle(1'b0, 1'b1, 8'hCC);
        cycle(1'b0, 1'b1, 8'hDD);
        chk("r4_lsb_word", {31'd0, if1.de_o, if1.pdata_o}, {31'd0, 1'b1, 32'hDDCCBBAA});
        cycle(1'b0, 1'b0, 8'h00);
        cycle(1'b0, 1'b0, 8'h00);

        // Three-beat line: padded on dut0, dropped on dut2
        cycle(1'b0, 1'b1, 8'h01);
        cycle(1'b0, 1'b1, 8'h02);
        chk("drop_cfg_word", {47'd0, if2.de_o, if2.pdata_o}, {47'd0, 1'b1, 16'h0102});
        cycle(1'b0, 1'b1, 8'h03);
        cycle(1'b0, 1'b0, 8'h00);
        chk("pad_word_eol", {45'd0, if0.de_o, if0.eol_o, if0.drop_o, if0.pdata_o},
            {45'd0, 1'b1, 1'b1, 1'b0, 16'h0300});
        chk("drop_eol", {61'd0, if2.de_o, if2.eol_o, if2.drop_o}, {61'd0, 1'b0, 1'b1, 1'b1});
        cycle(1'b0, 1'b0, 8'h00);

        // de_i held high across a VSYNC rise restarts at beat 0
        cycle(1'b0, 1'b1, 8'h55);
        cycle(1'b1, 1'b1, 8'h66);
        cycle(1'b0, 1'b1, 8'h77);
        cycle(1'b0, 1'b1, 8'h88);
        chk("restart_word", {46'd0, if0.de_o, if0.sof_o, if0.pdata_o}, {46'd0, 1'b1, 1'b1, 16'h7788});
        cycle(1'b0, 1'b0, 8'h00);

        vs_r = 1'b0;
        de_r = 1'b0;
        for (int i = 0; i < 1500; i++) begin
            vs_r = ($urandom_range(0, 149) == 0);
            if (de_r) de_r = ($urandom_range(0, 9) != 0);
            else      de_r = ($urandom_range(0, 9) < 3);
            d_r = 8'($urandom_range(0, 255));
            cycle(vs_r, de_r, d_r);
        end
        cycle(1'b0, 1'b0, 8'h00);

        // Asynchronous reset in the middle of a word
        cycle(1'b1, 1'b0, 8'h00);
        cycle(1'b0, 1'b0, 8'h00);
        cycle(1'b0, 1'b1, 8'h5A);
        cycle(1'b0, 1'b1, 8'hA5);
        cycle(1'b0, 1'b1, 8'h3C);
        #1 rst = 1'b1;
        #1;
        chk("async_rst_r2", got_vec(0), 64'd0);
        chk("async_rst_r4", got_vec(1), 64'd0);
        chk("async_rst_drop", got_vec(2), 64'd0);
`ifdef CMOS_PACK_LINECNT_EN
        chk("async_rst_cnt", {40'd0, lc0, wc0}, 64'd0);
`endif
        #1 rst = 1'b0;
        model_reset();
        cycle(1'b0, 1'b1, 8'h11);
        cycle(1'b0, 1'b1, 8'h22);
        chk("wait_vs_ignored", {63'd0, if0.de_o}, 64'd0);
        cycle(1'b0, 1'b0, 8'h00);

        // Three lines of four beats for the line/word counters
        cycle(1'b1, 1'b0, 8'h00);
        cycle(1'b0, 1'b0, 8'h00);
        for (int ln = 1; ln <= 3; ln++) begin
            for (int b = 0; b < 4; b++) cycle(1'b0, 1'b1, 8'(16 * ln + b));
            cycle(1'b0, 1'b0, 8'h00);
            chk($sformatf("line%0d_eol", ln), {63'd0, if0.eol_o}, 64'd1);
`ifdef CMOS_PACK_LINECNT_EN
            chk($sformatf("line%0d_cnt", ln), {40'd0, lc0, wc0}, {40'd0, 12'(ln), 12'd2});
`endif
            cycle(1'b0, 1'b0, 8'h00);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/cmos_pixel_packer.md
Name: cmos_pixel_packer

Overview:
- Parametrised CMOS DVP beat packer: assembles RATIO consecutive IN_W-bit sensor beats into one OUT_W = IN_W*RATIO word.
- Runs entirely in the pclk domain. Replaces divided-clock output with a single-cycle valid strobe.
- Adds frame arming on VSYNC, line-end flush and padding, byte-order selection, and SOF/EOL markers.
- Sits between the sensor input pins and the pixel FIFO / frame-buffer writer.

Parameters:
- IN_W, 8, sensor beat width in bits.
- RATIO, 2, beats per output word (2..8); OUT_W = IN_W*RATIO (localparam).
- MSB_FIRST, 1, 1: first beat lands in the top IN_W bits; 0: first beat lands in the bottom bits.
- PAD_PARTIAL, 1, 1: emit a zero-padded word at line end; 0: drop the partial word.
- CNT_W, 12, width of the optional line and word counters.

Ports:
- pclk  in  1  sensor pixel clock, all logic on rising edge
- rst  in  1  asynchronous, active-high reset
- vs_i  in  1  sensor VSYNC, active high
- de_i  in  1  sensor data enable / HREF
- pdata_i  in  IN_W  sensor beat
- vs_o  out  1  vs_i delayed one pclk
- de_o  out  1  one-cycle valid strobe for pdata_o
- pdata_o  out  OUT_W  packed word, held until the next de_o
- sof_o  out  1  high with the first de_o of each frame
- eol_o  out  1  one-cycle end-of-line pulse
- drop_o  out  1  one-cycle pulse when a partial word is discarded

Behaviour:
- Reset, asynchronous:
  - all outputs 0; beat counter 0; state S_WAIT_VS; vs_r=0, de_r=0; sof_pending=0.
- Input sampling:
  - vs_i and de_i are registered each cycle into vs_r and de_r.
  - vs_rise = vs_i & ~vs_r.
  - de_fall = de_r & ~de_i.
- State machine:
  - S_WAIT_VS: all beats ignored. vs_rise -> S_IDLE and sets sof_pending.
  - S_IDLE: de_i=1 -> capture beat 0 and go to S_PACK.
  - S_PACK: while de_i=1, capture beats. de_fall -> line-end handling, then S_IDLE.
  - vs_rise in S_IDLE or S_PACK: beat counter cleared, shift register cleared, partial data discarded with no de_o and no drop_o, sof_pending set, state -> S_IDLE. vs_rise has priority over de_i in the same cycle.
- Packing:
  - Beat counter runs 0..RATIO-1 and wraps to 0 after beat RATIO-1.
  - Beat k is placed in lane k. With MSB_FIRST=1, lane k = bits [OUT_W-1-k*IN_W -: IN_W]; with MSB_FIRST=0, lane k = bits [k*IN_W +: IN_W].
  - Latency: when beat RATIO-1 is sampled at edge N, de_o=1 and pdata_o is valid in the cycle after edge N (registered, one clock). Back-to-back words are supported: one de_o every RATIO cycles under continuous de_i.
- Line end (de_fall, evaluated in S_PACK):
  - Beat counter = 0: no word; eol_o=1 next cycle.
  - Beat counter ≠ 0 and PAD_PARTIAL=1: emit the assembled lanes, unfilled lanes 0. de_o=1 and eol_o=1 in the same cycle.
  - Beat counter ≠ 0 and PAD_PARTIAL=0: no de_o; drop_o=1 and eol_o=1 in the same cycle.
  - Beat counter returns to 0 in every case.
- sof_o: equals de_o & sof_pending. sof_pending clears on that word.
- de_i held high across vs_rise: counting restarts at beat 0 on the next de_i=1 sample.
- pdata_o changes only when de_o=1.

Optional Feature:
- Macro CMOS_PACK_LINECNT_EN.
- Defined, adds two ports:
  - line_cnt_o out CNT_W: counts eol_o pulses and clears on vs_rise.
  - word_cnt_o out CNT_W: counts de_o in the current line and clears in the cycle after eol_o.
  - Both reset to 0, saturate at all-ones and do not wrap.
- Undefined: both ports and both counters are absent. All other behaviour is identical.

Test Plan:
- No vs_rise after reset, de_i=1 with pdata_i 0x11,0x22 -> de_o remains 0 and no output is produced.
- vs_rise, then IN_W=8, RATIO=2, MSB_FIRST=1, beats 0x12,0x34,0x56,0x78 -> de_o at +1 cycle after 0x34 with 0x1234; at +1 after 0x78 with 0x5678; sof_o only on 0x1234.
- MSB_FIRST=0, RATIO=4, beats 0xAA,0xBB,0xCC,0xDD -> pdata_o=0xDDCCBBAA on a single de_o.
- RATIO=2, 3-beat line 0x01,0x02,0x03 -> words 0x0102 then 0x0300 with de_o+eol_o together. Same line with PAD_PARTIAL=0 -> only 0x0102, then drop_o+eol_o together.
- vs_rise mid-word after beat 0x9A -> no de_o, no drop_o. Next line 0x11,0x22 -> 0x1122 with sof_o=1.
- With CMOS_PACK_LINECNT_EN, 3 lines of 4 beats (RATIO=2) -> word_cnt_o reaches 2 each line and line_cnt_o=3. Asynchronous rst asserted mid-line -> all outputs 0 immediately and state returns to S_WAIT_VS.
